// File: rtl/video_mnist_pkg.sv
// Constants shared by the MNIST overlay stages (argmax and colour).
package video_mnist_pkg;

   localparam int NUM_CLASS     = 10;
   localparam int TNUMBER_WIDTH = 4;
   localparam int TCOUNT_WIDTH  = 4;

   // Number of surviving candidates after `level` pairwise reductions of n entries.
   function automatic int level_size(input int n, input int level);
      return (n + (1 << level) - 1) >> level;
   endfunction

endpackage

// File: rtl/video_mnist_argmax_node.sv
// One (index,count) compare of the argmax tree; input a always carries the lower index.
module video_mnist_argmax_node
   import video_mnist_pkg::*;
#(
   parameter int NUMBER_WIDTH = TNUMBER_WIDTH,
   parameter int COUNT_WIDTH  = TCOUNT_WIDTH
) (
   input  logic [NUMBER_WIDTH-1:0] a_number,
   input  logic [COUNT_WIDTH-1:0]  a_count,
   input  logic [NUMBER_WIDTH-1:0] b_number,
   input  logic [COUNT_WIDTH-1:0]  b_count,
   output logic [NUMBER_WIDTH-1:0] number,
   output logic [COUNT_WIDTH-1:0]  count
);

   // Strict greater-than keeps a on ties, so the lower class index wins.
   always_comb begin
      number = a_number;
      count  = a_count;
      if (b_count > a_count) begin
         number = b_number;
         count  = b_count;
      end
   end

endmodule

// File: rtl/video_mnist_argmax.sv
// Pipelined argmax over NUM_CLASS vote counts; video sideband travels beat-aligned with it.
module video_mnist_argmax
   import video_mnist_pkg::*;
#(
   parameter int TUSER_WIDTH   = 1,
   parameter int TDATA_WIDTH   = 24,
   parameter int TNUMBER_WIDTH = video_mnist_pkg::TNUMBER_WIDTH,
   parameter int TCOUNT_WIDTH  = video_mnist_pkg::TCOUNT_WIDTH,
   parameter int NUM_CLASS     = video_mnist_pkg::NUM_CLASS
) (
   input  logic                              aclk,
   input  logic                              areset,
   input  logic [TUSER_WIDTH-1:0]            s_axi4s_tuser,
   input  logic                              s_axi4s_tlast,
   input  logic [TDATA_WIDTH-1:0]            s_axi4s_tdata,
   input  logic                              s_axi4s_tbinary,
   input  logic [NUM_CLASS*TCOUNT_WIDTH-1:0] s_axi4s_tcount,
   input  logic                              s_axi4s_tvalid,
   output logic                              s_axi4s_tready,
   output logic [TUSER_WIDTH-1:0]            m_axi4s_tuser,
   output logic                              m_axi4s_tlast,
   output logic [TNUMBER_WIDTH-1:0]          m_axi4s_tnumber,
   output logic [TCOUNT_WIDTH-1:0]           m_axi4s_tcount,
   output logic [TDATA_WIDTH-1:0]            m_axi4s_tdata,
   output logic                              m_axi4s_tbinary,
   output logic                              m_axi4s_tvalid,
   input  logic                              m_axi4s_tready
);

   localparam int STAGES = $clog2(NUM_CLASS);

   if (NUM_CLASS < 2) begin : g_bad_class
      $error("video_mnist_argmax: NUM_CLASS must be at least 2");
   end
   if ($clog2(NUM_CLASS) > TNUMBER_WIDTH) begin : g_bad_width
      $error("video_mnist_argmax: TNUMBER_WIDTH too narrow for NUM_CLASS indices");
   end

   logic en;

   // Level l of the tree as seen by the compare nodes (level 0 is the input beat).
   logic [TCOUNT_WIDTH-1:0]  cnt_v [0:STAGES-1][0:NUM_CLASS-1];
   logic [TNUMBER_WIDTH-1:0] idx_v [0:STAGES-1][0:NUM_CLASS-1];
   logic [TCOUNT_WIDTH-1:0]  cnt_d [1:STAGES][0:NUM_CLASS-1];
   logic [TNUMBER_WIDTH-1:0] idx_d [1:STAGES][0:NUM_CLASS-1];
   logic [TCOUNT_WIDTH-1:0]  cnt_p [1:STAGES][0:NUM_CLASS-1];
   logic [TNUMBER_WIDTH-1:0] idx_p [1:STAGES][0:NUM_CLASS-1];

   logic                   vld_p  [1:STAGES];
   logic [TUSER_WIDTH-1:0] user_p [1:STAGES];
   logic                   last_p [1:STAGES];
   logic [TDATA_WIDTH-1:0] data_p [1:STAGES];
   logic                   bin_p  [1:STAGES];

   // Whole pipeline advances as one; a held output freezes every stage.
   assign en             = m_axi4s_tready || !vld_p[STAGES];
   assign s_axi4s_tready = en;

   for (genvar i = 0; i < NUM_CLASS; i++) begin : g_in
      assign cnt_v[0][i] = s_axi4s_tcount[i*TCOUNT_WIDTH +: TCOUNT_WIDTH];
      assign idx_v[0][i] = TNUMBER_WIDTH'(i);
   end

   for (genvar l = 1; l < STAGES; l++) begin : g_fwd
      assign cnt_v[l] = cnt_p[l];
      assign idx_v[l] = idx_p[l];
   end

   for (genvar l = 0; l < STAGES; l++) begin : g_lvl
      localparam int N_IN  = level_size(NUM_CLASS, l);
      localparam int N_OUT = level_size(NUM_CLASS, l + 1);
      for (genvar i = 0; i < NUM_CLASS; i++) begin : g_el
         if (2*i + 1 < N_IN) begin : g_node
            video_mnist_argmax_node #(
               .NUMBER_WIDTH (TNUMBER_WIDTH),
               .COUNT_WIDTH  (TCOUNT_WIDTH)
            ) u_node (
               .a_number (idx_v[l][2*i]),
               .a_count  (cnt_v[l][2*i]),
               .b_number (idx_v[l][2*i+1]),
               .b_count  (cnt_v[l][2*i+1]),
               .number   (idx_d[l+1][i]),
               .count    (cnt_d[l+1][i])
            );
         end else if (i < N_OUT) begin : g_pass
            assign idx_d[l+1][i] = idx_v[l][2*i];
            assign cnt_d[l+1][i] = cnt_v[l][2*i];
         end else begin : g_unused
            assign idx_d[l+1][i] = '0;
            assign cnt_d[l+1][i] = '0;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         for (int s = 1; s <= STAGES; s++) begin
            vld_p[s]  <= 1'b0;
            user_p[s] <= '0;
            last_p[s] <= 1'b0;
            data_p[s] <= '0;
            bin_p[s]  <= 1'b0;
            for (int i = 0; i < NUM_CLASS; i++) begin
               cnt_p[s][i] <= '0;
               idx_p[s][i] <= '0;
            end
         end
      end else if (en) begin
         vld_p[1]  <= s_axi4s_tvalid;
         user_p[1] <= s_axi4s_tuser;
         last_p[1] <= s_axi4s_tlast;
         data_p[1] <= s_axi4s_tdata;
         bin_p[1]  <= s_axi4s_tbinary;
         for (int s = 2; s <= STAGES; s++) begin
            vld_p[s]  <= vld_p[s-1];
            user_p[s] <= user_p[s-1];
            last_p[s] <= last_p[s-1];
            data_p[s] <= data_p[s-1];
            bin_p[s]  <= bin_p[s-1];
         end
         for (int s = 1; s <= STAGES; s++) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
               cnt_p[s][i] <= cnt_d[s][i];
               idx_p[s][i] <= idx_d[s][i];
            end
         end
      end
   end

   assign m_axi4s_tvalid  = vld_p[STAGES];
   assign m_axi4s_tuser   = user_p[STAGES];
   assign m_axi4s_tlast   = last_p[STAGES];
   assign m_axi4s_tdata   = data_p[STAGES];
   assign m_axi4s_tbinary = bin_p[STAGES];
   assign m_axi4s_tnumber = idx_p[STAGES][0];
   assign m_axi4s_tcount  = cnt_p[STAGES][0];

endmodule

// File: tb/tb_video_mnist_argmax.sv
// Scoreboard bench for video_mnist_argmax: driver queues expected beats, monitor pops and compares.
module tb_video_mnist_argmax;

   localparam int NC = 10;
   localparam int CW = 4;
   localparam int NW = 4;
   localparam int DW = 24;
   localparam int UW = 1;

   logic             aclk = 1'b0;
   logic             areset;
   logic [UW-1:0]    s_axi4s_tuser;
   logic             s_axi4s_tlast;
   logic [DW-1:0]    s_axi4s_tdata;
   logic             s_axi4s_tbinary;
   logic [NC*CW-1:0] s_axi4s_tcount;
   logic             s_axi4s_tvalid;
   logic             s_axi4s_tready;
   logic [UW-1:0]    m_axi4s_tuser;
   logic             m_axi4s_tlast;
   logic [NW-1:0]    m_axi4s_tnumber;
   logic [CW-1:0]    m_axi4s_tcount;
   logic [DW-1:0]    m_axi4s_tdata;
   logic             m_axi4s_tbinary;
   logic             m_axi4s_tvalid;
   logic             m_axi4s_tready;

   video_mnist_argmax #(
      .TUSER_WIDTH   (UW),
      .TDATA_WIDTH   (DW),
      .TNUMBER_WIDTH (NW),
      .TCOUNT_WIDTH  (CW),
      .NUM_CLASS     (NC)
   ) dut (
      .aclk            (aclk),
      .areset          (areset),
      .s_axi4s_tuser   (s_axi4s_tuser),
      .s_axi4s_tlast   (s_axi4s_tlast),
      .s_axi4s_tdata   (s_axi4s_tdata),
      .s_axi4s_tbinary (s_axi4s_tbinary),
      .s_axi4s_tcount  (s_axi4s_tcount),
      .s_axi4s_tvalid  (s_axi4s_tvalid),
      .s_axi4s_tready  (s_axi4s_tready),
      .m_axi4s_tuser   (m_axi4s_tuser),
      .m_axi4s_tlast   (m_axi4s_tlast),
      .m_axi4s_tnumber (m_axi4s_tnumber),
      .m_axi4s_tcount  (m_axi4s_tcount),
      .m_axi4s_tdata   (m_axi4s_tdata),
      .m_axi4s_tbinary (m_axi4s_tbinary),
      .m_axi4s_tvalid  (m_axi4s_tvalid),
      .m_axi4s_tready  (m_axi4s_tready)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [UW-1:0] user;
      logic          last;
      logic [NW-1:0] num;
      logic [CW-1:0] cnt;
      logic [DW-1:0] data;
      logic          bin;
      int            cyc;
      bit            lat;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;
   bit   rnd_ready = 1'b0;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tnumber, m_axi4s_tcount,
                  m_axi4s_tdata, m_axi4s_tbinary});
   endfunction

   // Linear-scan reference: first strictly larger count replaces the best.
   function automatic logic [NW+CW-1:0] ref_argmax(input logic [NC*CW-1:0] c);
      logic [CW-1:0] best;
      logic [NW-1:0] bi;
      best = c[CW-1:0];
      bi   = '0;
      for (int k = 1; k < NC; k++) begin
         if (c[k*CW +: CW] > best) begin
            best = c[k*CW +: CW];
            bi   = NW'(k);
         end
      end
      return {bi, best};
   endfunction

   task automatic send(input logic [UW-1:0] u, input logic l, input logic [DW-1:0] d,
                       input logic b, input logic [NC*CW-1:0] c,
                       input logic [NW-1:0] en_num, input logic [CW-1:0] en_cnt, input bit lat);
      exp_t e;
      int   tries;
      tries = 0;
      s_axi4s_tuser   = u;
      s_axi4s_tlast   = l;
      s_axi4s_tdata   = d;
      s_axi4s_tbinary = b;
      s_axi4s_tcount  = c;
      s_axi4s_tvalid  = 1'b1;
      forever begin
         m_axi4s_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (s_axi4s_tready) begin
            e = '{u, l, en_num, en_cnt, d, b, cyc, lat};
            q.push_back(e);
            @(posedge aclk);
            @(negedge aclk);
            break;
         end
         tries++;
         if (tries > 1000) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: tready stuck low, got 0 want 1");
            break;
         end
         @(posedge aclk);
         @(negedge aclk);
      end
      s_axi4s_tvalid = 1'b0;
   endtask

   task automatic send_model(input logic [UW-1:0] u, input logic l, input logic [DW-1:0] d,
                             input logic b, input logic [NC*CW-1:0] c, input bit lat);
      logic [NW+CW-1:0] r;
      r = ref_argmax(c);
      send(u, l, d, b, c, r[NW+CW-1:CW], r[CW-1:0], lat);
   endtask

   task automatic idle(input int n);
      s_axi4s_tvalid = 1'b0;
      m_axi4s_tready = 1'b1;
      repeat (n) begin
         @(posedge aclk);
         @(negedge aclk);
      end
   endtask

   initial begin : monitor
      exp_t        e;
      logic        stalled;
      logic [63:0] held;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge aclk);
         #2;
         if (areset) begin
            stalled = 1'b0;
         end else begin
            check("tready", 64'(s_axi4s_tready), 64'(m_axi4s_tready || !m_axi4s_tvalid));
            if (stalled) check("hold", {outs()[62:0], m_axi4s_tvalid}, held);
            if (m_axi4s_tvalid && m_axi4s_tready) begin
               if (q.size() == 0) begin
                  checks++;
                  fails++;
                  $display("FAIL unexpected_beat: got %h want no beat", outs());
               end else begin
                  e = q.pop_front();
                  check("beat", outs(), 64'({e.user, e.last, e.num, e.cnt, e.data, e.bin}));
                  if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd4);
               end
            end
            stalled = m_axi4s_tvalid && !m_axi4s_tready;
            held    = {outs()[62:0], m_axi4s_tvalid};
         end
      end
   end

   initial begin : driver
      logic [NC*CW-1:0] c;
      int               waits;
      areset          = 1'b1;
      s_axi4s_tuser   = '0;
      s_axi4s_tlast   = 1'b0;
      s_axi4s_tdata   = '0;
      s_axi4s_tbinary = 1'b0;
      s_axi4s_tcount  = '0;
      s_axi4s_tvalid  = 1'b0;
      m_axi4s_tready  = 1'b1;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      #1;
      check("reset_state", {outs()[62:0], m_axi4s_tvalid}, 64'd0);
      areset = 1'b0;
      @(negedge aclk);

      // Directed vectors, downstream always ready, fixed 4-cycle latency.
      send(1'b0, 1'b0, 24'h123456, 1'b1, 40'h00_0000_7000, 4'd3, 4'd7,  1'b1);
      send(1'b0, 1'b0, 24'h0F0F0F, 1'b0, 40'h19_1111_1911, 4'd2, 4'd9,  1'b1);
      send(1'b0, 1'b0, 24'hA5B6C7, 1'b1, 40'h00_0000_0000, 4'd0, 4'd0,  1'b1);
      send(1'b0, 1'b0, 24'hA5B6C7, 1'b0, 40'h00_0000_0000, 4'd0, 4'd0,  1'b1);
      send(1'b1, 1'b0, 24'h000001, 1'b1, 40'hF0_0000_0000, 4'd9, 4'd15, 1'b1);
      send(1'b0, 1'b1, 24'h000002, 1'b0, 40'h0F_0000_0000, 4'd8, 4'd15, 1'b1);
      send(1'b0, 1'b0, 24'h000003, 1'b1, 40'hEE_0000_0000, 4'd8, 4'd14, 1'b1);
      send(1'b0, 1'b0, 24'h000004, 1'b0, 40'h44_4444_4444, 4'd0, 4'd4,  1'b1);
      send(1'b0, 1'b0, 24'h000005, 1'b1, 40'h00_0000_0005, 4'd0, 4'd5,  1'b1);
      send(1'b0, 1'b0, 24'h000006, 1'b0, 40'h12_3456_7898, 4'd1, 4'd9,  1'b1);
      idle(8);

      // Reset with three beats in flight: they must vanish.
      send(1'b1, 1'b0, 24'h111111, 1'b1, 40'h00_0000_0300, 4'd2, 4'd3, 1'b1);
      send(1'b0, 1'b0, 24'h222222, 1'b1, 40'h00_0000_0030, 4'd1, 4'd3, 1'b1);
      send(1'b0, 1'b1, 24'h333333, 1'b1, 40'h00_0000_0003, 4'd0, 4'd3, 1'b1);
      areset = 1'b1;
      q.delete();
      @(posedge aclk);
      @(negedge aclk);
      #1;
      check("reset_flush", {outs()[62:0], m_axi4s_tvalid}, 64'd0);
      areset = 1'b0;
      idle(8);

      // Random beats with downstream back-pressure.
      rnd_ready = 1'b1;
      for (int n = 0; n < 100; n++) begin
         for (int k = 0; k < NC; k++) c[k*CW +: CW] = CW'($urandom_range(0, 7));
         send_model(UW'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom),
                    1'($urandom_range(0, 1)), c, 1'b0);
      end
      rnd_ready = 1'b0;
      idle(8);

      // One 640-pixel line: tuser on the first beat, tlast on the last.
      for (int n = 0; n < 640; n++) begin
         for (int k = 0; k < NC; k++) c[k*CW +: CW] = CW'($urandom_range(0, 15));
         send_model(UW'(n == 0), n == 639, DW'(n), 1'(n % 3 == 0), c, 1'b1);
      end

      s_axi4s_tvalid = 1'b0;
      m_axi4s_tready = 1'b1;
      waits = 0;
      while (q.size() != 0 && waits < 300) begin
         @(posedge aclk);
         @(negedge aclk);
         waits++;
      end
      idle(2);
      check("drain", 64'(q.size()), 64'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/video_mnist_argmax.md
VIDEO_MNIST_ARGMAX -- requirements
Module: video_mnist_argmax

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- TUSER_WIDTH, 1, sideband user width
- TDATA_WIDTH, 24, pixel data width
- TNUMBER_WIDTH, 4, class index width
- TCOUNT_WIDTH, 4, per-class vote count width
- NUM_CLASS, 10, number of classes
REQ-002 Ports SHALL be, one per line (name direction width meaning):
- aclk  in  1  single clock, all logic on rising edge
- areset  in  1  reset, synchronous, active-high
- s_axi4s_tuser  in  TUSER_WIDTH  frame-start sideband
- s_axi4s_tlast  in  1  end-of-line
- s_axi4s_tdata  in  TDATA_WIDTH  source pixel
- s_axi4s_tbinary  in  1  binarized pixel
- s_axi4s_tcount  in  NUM_CLASS*TCOUNT_WIDTH  class k vote count at bits [k*TCOUNT_WIDTH +: TCOUNT_WIDTH]
- s_axi4s_tvalid  in  1  input valid
- s_axi4s_tready  out  1  input ready
- m_axi4s_tuser  out  TUSER_WIDTH  delayed tuser
- m_axi4s_tlast  out  1  delayed tlast
- m_axi4s_tnumber  out  TNUMBER_WIDTH  winning class index
- m_axi4s_tcount  out  TCOUNT_WIDTH  winning class vote count
- m_axi4s_tdata  out  TDATA_WIDTH  delayed tdata
- m_axi4s_tbinary  out  1  delayed tbinary
- m_axi4s_tvalid  out  1  output valid
- m_axi4s_tready  in  1  output ready

Function
REQ-003 Block SHALL output, per beat, the index and value of the maximum of the NUM_CLASS input counts (unsigned compare).
REQ-004 Ties SHALL resolve to the lowest class index.
REQ-005 All-zero counts SHALL yield tnumber=0, tcount=0.
REQ-006 Reduction SHALL be a registered binary tree, one compare level per stage; NUM_CLASS=10 gives 4 stages (10->5->3->2->1), odd element passing through unchanged with its index.
REQ-007 Latency SHALL be exactly ceil(log2(NUM_CLASS)) accepted-beat stages (4 for default) from input acceptance to m_axi4s_tvalid, absent stalls.
REQ-008 tuser, tlast, tdata, tbinary and tvalid SHALL be delayed through the same stages, staying beat-aligned with tnumber/tcount.
REQ-009 s_axi4s_tready SHALL equal (m_axi4s_tready || !m_axi4s_tvalid), combinational.
REQ-010 All pipeline registers SHALL advance together only when s_axi4s_tready=1; when 0, all hold (global stall, outputs stable).
REQ-011 Bubbles (tvalid=0 beats) SHALL propagate as tvalid=0 stages; payload of invalid stages is don't-care.
REQ-012 Output tnumber width SHALL be TNUMBER_WIDTH; a winning index wider than that is a parameter error, rejected at elaboration.
REQ-013 Throughput SHALL be one beat per clock when m_axi4s_tready is held 1.

Reset
REQ-014 While areset=1 at a clock edge, all stage valid bits SHALL clear, so m_axi4s_tvalid=0 on the next cycle.
REQ-015 On reset, m_axi4s_tuser, tlast, tbinary, tnumber, tcount and tdata SHALL be 0.
REQ-016 Reset mid-stream SHALL discard all in-flight beats; no partial beat SHALL emerge afterwards.
REQ-017 Reset SHALL take priority over stall.

Structure
REQ-018 Shared package/header video_mnist_pkg SHALL hold NUM_CLASS=10 and default TNUMBER_WIDTH/TCOUNT_WIDTH, shared with the colour stage.
REQ-019 One sub-module video_mnist_argmax_node SHALL implement a single two-input (index,count) compare with lower-index-wins; the tree SHALL be generated from it.
REQ-020 Block output ports SHALL connect directly to the downstream colour stage's tnumber/tcount/tdata/tbinary inputs.

Verification
REQ-021 counts={0,0,0,7,0,0,0,0,0,0}, tready=1 -> tnumber=3, tcount=7, output exactly 4 cycles later.
REQ-022 counts class2=9 and class8=9, others 1 -> tnumber=2, tcount=9 (tie to lowest).
REQ-023 All counts 0 -> tnumber=0, tcount=0; tdata 0xA5B6C7 and tbinary pass unchanged.
REQ-024 100 random beats with random m_axi4s_tready toggling -> output order, count and values match reference model; outputs stable while stalled.
REQ-025 Assert areset with 3 beats in flight -> m_axi4s_tvalid=0 next cycle; those beats never appear.
REQ-026 Line of 640 beats, tuser on first, tlast on last -> tuser and tlast appear on the matching output beats only.
